// File: rtl/mac_pe_pkg.sv
// rtl/mac_pe_pkg.sv - shared widths and overflow/saturation helpers for the SIMD MAC PE.
package mac_pe_pkg;

  typedef struct packed {
    logic ovf;
    logic clamp_pos;
    logic clamp_neg;
  } sat_ctl_t;

  function automatic int psum_width(input int lanes, input int in_w);
    return 2 * in_w + $clog2(lanes);
  endfunction

  function automatic int klen_width(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  // Takes the two MSBs of a one-bit-wider sum: they differ exactly when it does not fit.
  function automatic sat_ctl_t sat_ctl(input logic sign_ext, input logic sign, input logic sat_en);
    sat_ctl_t c;
    c.ovf       = sign_ext ^ sign;
    c.clamp_pos = c.ovf & sat_en & ~sign_ext;
    c.clamp_neg = c.ovf & sat_en & sign_ext;
    return c;
  endfunction

endpackage

// File: rtl/mac_lane_dot.sv
// rtl/mac_lane_dot.sv - combinational signed per-lane multiply and lossless reduction.
module mac_lane_dot import mac_pe_pkg::*; #(
  parameter int NUM_LANES = 4,
  parameter int IN_WIDTH  = 8,
  parameter int PSUM_W    = psum_width(NUM_LANES, IN_WIDTH)
) (
  input  logic [NUM_LANES*IN_WIDTH-1:0] a_i,
  input  logic [NUM_LANES*IN_WIDTH-1:0] b_i,
  output logic signed [PSUM_W-1:0]      psum_o
);

  logic signed [2*IN_WIDTH-1:0] prod [NUM_LANES];
  logic signed [PSUM_W-1:0]     sum;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign prod[l] = $signed(a_i[l*IN_WIDTH +: IN_WIDTH]) * $signed(b_i[l*IN_WIDTH +: IN_WIDTH]);
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      sum = sum + PSUM_W'(prod[l]);
    end
  end

  assign psum_o = sum;

endmodule

// File: rtl/mac_pe_simd.sv
// rtl/mac_pe_simd.sv - multi-lane MAC PE: product stage, accumulate stage, backpressured result register.
module mac_pe_simd import mac_pe_pkg::*; #(
  parameter int NUM_LANES = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int MAX_K     = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_LANES*IN_WIDTH-1:0]    a_i,
  input  logic [NUM_LANES*IN_WIDTH-1:0]    b_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [klen_width(MAX_K)-1:0]     k_len_i,
  input  logic                             sat_en_i,
  input  logic                             acc_clr_i,
  output logic signed [ACC_WIDTH-1:0]      out_data_o,
  output logic                             out_ovf_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic                             busy_o
);

  localparam int PSUM_W = psum_width(NUM_LANES, IN_WIDTH);
  localparam int KW     = klen_width(MAX_K);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [KW-1:0]               cnt_q, cnt_d, klen_last_q, klen_last_d;
  logic                        sat_q, sat_d;
  logic                        p_valid_q, p_valid_d, p_first_q, p_first_d;
  logic                        p_last_q, p_last_d, p_sat_q, p_sat_d;
  logic signed [PSUM_W-1:0]    psum_q, psum_d, dot_psum;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic                        ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

  logic                        first_beat, beat_last, stall, accept, advance, sticky;
  logic [KW-1:0]               klen_eff, last_idx;
  logic signed [ACC_WIDTH:0]   base, sum;
  logic signed [ACC_WIDTH-1:0] result;
  sat_ctl_t                    sc;

  mac_lane_dot #(
    .NUM_LANES (NUM_LANES),
    .IN_WIDTH  (IN_WIDTH),
    .PSUM_W    (PSUM_W)
  ) u_dot (
    .a_i    (a_i),
    .b_i    (b_i),
    .psum_o (dot_psum)
  );

  assign first_beat = (cnt_q == '0);
  assign klen_eff   = (k_len_i == '0) ? KW'(1) : k_len_i;
  assign last_idx   = first_beat ? (klen_eff - KW'(1)) : klen_last_q;
  assign beat_last  = (cnt_q == last_idx);

  assign stall      = p_valid_q & p_last_q & out_valid_q & ~out_ready_i;
  assign in_ready_o = ~stall & ~acc_clr_i;
  assign accept     = in_valid_i & in_ready_o;
  assign advance    = p_valid_q & ~stall & ~acc_clr_i;

  // Accumulate one bit wider than the result so overflow is visible in the top two bits.
  assign base   = p_first_q ? '0 : (ACC_WIDTH+1)'(acc_q);
  assign sum    = base + (ACC_WIDTH+1)'(psum_q);
  assign sc     = sat_ctl(sum[ACC_WIDTH], sum[ACC_WIDTH-1], p_sat_q);
  assign result = sc.clamp_pos ? SAT_MAX : (sc.clamp_neg ? SAT_MIN : sum[ACC_WIDTH-1:0]);
  assign sticky = (~p_first_q & ovf_q) | sc.ovf;

  always_comb begin
    cnt_d       = cnt_q;
    klen_last_d = klen_last_q;
    sat_d       = sat_q;
    p_valid_d   = p_valid_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    p_sat_d     = p_sat_q;
    psum_d      = psum_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (acc_clr_i) begin
      cnt_d     = '0;
      p_valid_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      if (!stall) begin
        p_valid_d = accept;
      end
      if (accept) begin
        psum_d    = dot_psum;
        p_first_d = first_beat;
        p_last_d  = beat_last;
        p_sat_d   = first_beat ? sat_en_i : sat_q;
        cnt_d     = beat_last ? '0 : cnt_q + KW'(1);
        if (first_beat) begin
          klen_last_d = klen_eff - KW'(1);
          sat_d       = sat_en_i;
        end
      end
      if (advance) begin
        acc_d = result;
        ovf_d = sticky;
      end
    end

    // A handshake in the same cycle as a load is absorbed by the load: no bubble.
    if (advance && p_last_q) begin
      out_data_d  = result;
      out_ovf_d   = sticky;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      klen_last_q <= '0;
      sat_q       <= 1'b0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_sat_q     <= 1'b0;
      psum_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      klen_last_q <= klen_last_d;
      sat_q       <= sat_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      p_sat_q     <= p_sat_d;
      psum_q      <= psum_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (cnt_q != '0) | p_valid_q;

endmodule

// File: tb/tb_mac_pe_simd.sv
// tb/tb_mac_pe_simd.sv - directed vector bench for mac_pe_simd at 32-bit and 18-bit accumulator widths.
module tb_mac_pe_simd;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid, sat_en, acc_clr, out_ready;
  logic [8:0]  k_len;

  logic               r32, v32, o32, bz32;
  logic signed [31:0] d32;
  logic               r18, v18, o18, bz18;
  logic signed [17:0] d18;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mac_pe_simd #(.NUM_LANES(4), .IN_WIDTH(8), .ACC_WIDTH(32), .MAX_K(256)) u32 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .in_valid_i(in_valid), .in_ready_o(r32),
    .k_len_i(k_len), .sat_en_i(sat_en), .acc_clr_i(acc_clr), .out_data_o(d32),
    .out_ovf_o(o32), .out_valid_o(v32), .out_ready_i(out_ready), .busy_o(bz32)
  );

  mac_pe_simd #(.NUM_LANES(4), .IN_WIDTH(8), .ACC_WIDTH(18), .MAX_K(256)) u18 (
    .clk_i(clk), .rst_i(rst), .a_i(a), .b_i(b), .in_valid_i(in_valid), .in_ready_o(r18),
    .k_len_i(k_len), .sat_en_i(sat_en), .acc_clr_i(acc_clr), .out_data_o(d18),
    .out_ovf_o(o18), .out_valid_o(v18), .out_ready_i(out_ready), .busy_o(bz18)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    bit          sat;
    int          beats;
    int          e32;
    bit          ov32;
    int          e18;
    bit          ov18;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] av, input logic [31:0] bv, input int k, input bit s);
    int t;
    a = av; b = bv; k_len = 9'(k); sat_en = s; in_valid = 1'b1;
    #1;
    t = 0;
    while (!r32 && t < 50) begin
      step();
      t++;
    end
    chk("beat_ready_wait", longint'(t < 50), 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string nm, input bit v, input longint e32, input bit ov32,
                         input longint e18, input bit ov18);
    chk({nm, "_valid32"}, longint'(v32), longint'(v));
    chk({nm, "_valid18"}, longint'(v18), longint'(v));
    if (v) begin
      chk({nm, "_data32"}, longint'(d32), e32);
      chk({nm, "_ovf32"}, longint'(o32), longint'(ov32));
      chk({nm, "_data18"}, longint'(d18), e18);
      chk({nm, "_ovf18"}, longint'(o18), longint'(ov18));
    end
  endtask

  logic [31:0] v70a, v70b, ones, neg128, pos127, mixa, mixb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    v70a   = pack4(1, 2, 3, 4);
    v70b   = pack4(5, 6, 7, 8);
    ones   = pack4(1, 1, 1, 1);
    neg128 = pack4(-128, -128, -128, -128);
    pos127 = pack4(127, 127, 127, 127);
    mixa   = pack4(-3, 2, 0, 1);
    mixb   = pack4(4, -5, 9, -1);

    vecs[0] = '{v70a,   v70b,   1, 1'b0, 1, 70,      1'b0, 70,      1'b0};
    vecs[1] = '{neg128, neg128, 3, 1'b1, 3, 196608,  1'b0, 131071,  1'b1};
    vecs[2] = '{neg128, neg128, 3, 1'b0, 3, 196608,  1'b0, -65536,  1'b1};
    vecs[3] = '{mixa,   mixb,   2, 1'b1, 2, -46,     1'b0, -46,     1'b0};
    vecs[4] = '{ones,   ones,   0, 1'b0, 1, 4,       1'b0, 4,       1'b0};
    vecs[5] = '{pos127, pos127, 4, 1'b1, 4, 258064,  1'b0, 131071,  1'b1};
    vecs[6] = '{neg128, pos127, 3, 1'b1, 3, -195072, 1'b0, -131072, 1'b1};
    vecs[7] = '{neg128, pos127, 3, 1'b0, 3, -195072, 1'b0, 67072,   1'b1};

    rst = 1'b1; a = '0; b = '0; in_valid = 1'b0; sat_en = 1'b0;
    acc_clr = 1'b0; out_ready = 1'b1; k_len = '0;
    step(); step(); step();
    chk_out("por", 1'b0, 0, 1'b0, 0, 1'b0);
    chk("por_data32", longint'(d32), 0);
    chk("por_busy32", longint'(bz32), 0);
    rst = 1'b0;
    step();
    chk("por_ready32", longint'(r32), 1);
    chk("por_ready18", longint'(r18), 1);

    foreach (vecs[i]) begin
      for (int bt = 0; bt < vecs[i].beats; bt++) begin
        send_beat(vecs[i].a, vecs[i].b, vecs[i].k, vecs[i].sat);
      end
      step();
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].e32, vecs[i].ov32, vecs[i].e18, vecs[i].ov18);
      step();
      chk($sformatf("vec%0d_clear", i), longint'(v32), 0);
    end

    // Backpressure: two single-beat products queued behind a stalled consumer.
    out_ready = 1'b0;
    send_beat(v70a, v70b, 1, 1'b0);
    send_beat(ones, ones, 1, 1'b0);
    chk("bp_ready_low", longint'(r32), 0);
    chk_out("bp_hold0", 1'b1, 70, 1'b0, 70, 1'b0);
    step(); step();
    chk_out("bp_hold2", 1'b1, 70, 1'b0, 70, 1'b0);
    chk("bp_busy", longint'(bz32), 1);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", longint'(r32), 1);
    step();
    chk_out("bp_second", 1'b1, 4, 1'b0, 4, 1'b0);
    step();
    chk("bp_drained", longint'(v32), 0);
    chk("bp_idle", longint'(bz32), 0);

    // Abort after two of four beats; the beat offered alongside the clear is dropped.
    send_beat(ones, ones, 4, 1'b0);
    send_beat(ones, ones, 4, 1'b0);
    chk("abort_busy_mid", longint'(bz32), 1);
    acc_clr = 1'b1; in_valid = 1'b1; a = pos127; b = pos127;
    #1;
    chk("abort_ready_low", longint'(r32), 0);
    step();
    acc_clr = 1'b0; in_valid = 1'b0;
    chk("abort_busy32", longint'(bz32), 0);
    chk("abort_busy18", longint'(bz18), 0);
    chk("abort_no_out", longint'(v32), 0);
    send_beat(v70a, v70b, 1, 1'b0);
    step();
    chk_out("abort_fresh", 1'b1, 70, 1'b0, 70, 1'b0);
    step();
    chk("abort_clear", longint'(v32), 0);
    chk("abort_idle", longint'(bz32), 0);

    // Clear wins over a last beat that would load the output this cycle.
    send_beat(v70a, v70b, 1, 1'b0);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    chk("clr_vs_load_valid", longint'(v32), 0);
    chk("clr_vs_load_busy", longint'(bz32), 0);

    // Reset while a result is pending and a second is stalled behind it.
    out_ready = 1'b0;
    send_beat(v70a, v70b, 1, 1'b0);
    send_beat(ones, ones, 1, 1'b0);
    chk("rst_pre_stall", longint'(r32), 0);
    rst = 1'b1; in_valid = 1'b1; a = ones; b = ones; k_len = 9'd4;
    step(); step(); step();
    chk_out("rst_hold", 1'b0, 0, 1'b0, 0, 1'b0);
    chk("rst_data32", longint'(d32), 0);
    chk("rst_data18", longint'(d18), 0);
    chk("rst_ovf32", longint'(o32), 0);
    chk("rst_busy32", longint'(bz32), 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("rst_ready_after", longint'(r32), 1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst_no_spurious%0d", c), longint'(v32), 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
